// File: rtl/line_fill_buffer.sv
// Cache line refill: issues one burst request, then gathers critical-word-first
// wrap-around beats into a full line and forwards the critical word early.
module line_fill_buffer #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_SIZE       = 512,
    parameter int NUM_SEGMENTS     = 16,
    parameter int NUM_SEGMENTS_LOG = 4,
    parameter int BYTE_OFFSET_LOG  = 2,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rdata_valid,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic                  fill_busy,
    output logic                  crit_word_valid,
    output logic [WORD_SIZE-1:0]  crit_word,
    output logic                  fill_done,
    output logic [BLOCK_SIZE-1:0] block_out
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        DONE
    } state_t;

    // Clearing the byte-offset bits yields base | (start_off << BYTE_OFFSET_LOG).
    localparam logic [ADDR_WIDTH-1:0] WORD_ALIGN_MASK =
        ~ADDR_WIDTH'((64'd1 << BYTE_OFFSET_LOG) - 64'd1);
    localparam logic [NUM_SEGMENTS_LOG-1:0] LAST_BEAT = NUM_SEGMENTS_LOG'(NUM_SEGMENTS - 1);

    state_t                      state_reg, state_next;
    logic [ADDR_WIDTH-1:0]       mem_req_addr_reg, mem_req_addr_next;
    logic [NUM_SEGMENTS_LOG-1:0] start_off_reg, start_off_next;
    logic [NUM_SEGMENTS_LOG-1:0] cnt_reg, cnt_next;
    logic                        crit_valid_reg, crit_valid_next;
    logic [WORD_SIZE-1:0]        crit_word_reg, crit_word_next;
    logic [BLOCK_SIZE-1:0]       block_reg, block_next;
    logic [NUM_SEGMENTS_LOG-1:0] slot;
    logic                        beat;

    assign beat = (state_reg == RECV) && mem_rdata_valid;
    // Natural NUM_SEGMENTS_LOG-bit overflow gives the wrap-around order.
    assign slot = start_off_reg + cnt_reg;

    always_comb begin
        state_next        = state_reg;
        mem_req_addr_next = mem_req_addr_reg;
        start_off_next    = start_off_reg;
        cnt_next          = cnt_reg;
        crit_valid_next   = 1'b0;
        crit_word_next    = crit_word_reg;
        case (state_reg)
            IDLE: begin
                if (fill_start) begin
                    mem_req_addr_next = fill_addr & WORD_ALIGN_MASK;
                    start_off_next    = fill_addr[BYTE_OFFSET_LOG +: NUM_SEGMENTS_LOG];
                    cnt_next          = '0;
                    state_next        = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (mem_rdata_valid) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == '0) begin
                        crit_valid_next = 1'b1;
                        crit_word_next  = mem_rdata;
                    end
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Each word slot only loads on the beat whose wrapped index selects it.
    generate
        for (genvar gi = 0; gi < NUM_SEGMENTS; gi++) begin : g_slot
            assign block_next[gi*WORD_SIZE +: WORD_SIZE] =
                (beat && slot == NUM_SEGMENTS_LOG'(gi)) ? mem_rdata
                                                        : block_reg[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            mem_req_addr_reg <= '0;
            start_off_reg    <= '0;
            cnt_reg          <= '0;
            crit_valid_reg   <= 1'b0;
            crit_word_reg    <= '0;
            block_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            mem_req_addr_reg <= mem_req_addr_next;
            start_off_reg    <= start_off_next;
            cnt_reg          <= cnt_next;
            crit_valid_reg   <= crit_valid_next;
            crit_word_reg    <= crit_word_next;
            block_reg        <= block_next;
        end
    end

    assign mem_req_valid   = (state_reg == REQ);
    assign mem_req_addr    = mem_req_addr_reg;
    assign fill_busy       = (state_reg != IDLE);
    assign fill_done       = (state_reg == DONE);
    assign crit_word_valid = crit_valid_reg;
    assign crit_word       = crit_word_reg;
    assign block_out       = block_reg;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: inputs driven and outputs sampled on the
// falling edge, each scenario task checks its own expectations inline.
module tb_line_fill_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fill_start = 1'b0;
    logic [31:0]  fill_addr = '0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_rdata_valid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         fill_busy;
    logic         crit_word_valid;
    logic [31:0]  crit_word;
    logic         fill_done;
    logic [511:0] block_out;

    int checks = 0;
    int failures = 0;

    line_fill_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .fill_start      (fill_start),
        .fill_addr       (fill_addr),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .fill_busy       (fill_busy),
        .crit_word_valid (crit_word_valid),
        .crit_word       (crit_word),
        .fill_done       (fill_done),
        .block_out       (block_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int idx);
        return block_out[idx*32 +: 32];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_fill(input logic [31:0] addr);
        fill_start = 1'b1;
        fill_addr  = addr;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic grant();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data);
        mem_rdata_valid = 1'b1;
        mem_rdata       = data;
        tick();
        mem_rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req_valid, fill_busy, crit_word_valid, fill_done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000",
                     {mem_req_valid, fill_busy, crit_word_valid, fill_done});
        end
        checks++;
        if (mem_req_addr !== 32'h0 || crit_word !== 32'h0 || block_out !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%h crit=%h block_nonzero=%b want all zero",
                     mem_req_addr, crit_word, block_out != '0);
        end
        $display("test_reset done");
    endtask

    // Offset 2: beat i lands in word (2+i)%16.
    task automatic test_crit_first();
        start_fill(32'h0000_1008);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1008 || fill_busy !== 1'b1) begin
            failures++;
            $display("FAIL crit_req valid=%b addr=%h busy=%b want 1 00001008 1",
                     mem_req_valid, mem_req_addr, fill_busy);
        end
        grant();
        for (int i = 0; i < 16; i++) begin
            send_beat(32'hA0 + 32'(i));
            if (i == 0) begin
                checks++;
                if (crit_word_valid !== 1'b1 || crit_word !== 32'hA0) begin
                    failures++;
                    $display("FAIL crit_pulse valid=%b word=%h want 1 000000a0",
                             crit_word_valid, crit_word);
                end
            end else if (i == 1) begin
                checks++;
                if (crit_word_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL crit_pulse_width valid=%b want 0", crit_word_valid);
                end
            end else if (i == 14) begin
                checks++;
                if (fill_done !== 1'b0) begin
                    failures++;
                    $display("FAIL crit_early_done fill_done=%b want 0", fill_done);
                end
            end
        end
        checks++;
        if (fill_done !== 1'b1) begin
            failures++;
            $display("FAIL crit_done fill_done=%b want 1", fill_done);
        end
        checks++;
        if (word_of(2) !== 32'hA0 || word_of(15) !== 32'hAD ||
            word_of(0) !== 32'hAE || word_of(1) !== 32'hAF) begin
            failures++;
            $display("FAIL crit_words w2=%h w15=%h w0=%h w1=%h want a0 ad ae af",
                     word_of(2), word_of(15), word_of(0), word_of(1));
        end
        tick();
        checks++;
        if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL crit_idle done=%b busy=%b want 0 0", fill_done, fill_busy);
        end
        $display("test_crit_first done");
    endtask

    task automatic test_req_hold();
        start_fill(32'h0000_2000);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2000) begin
                failures++;
                $display("FAIL req_hold cyc=%0d valid=%b addr=%h want 1 00002000",
                         k, mem_req_valid, mem_req_addr);
            end
            tick();
        end
        grant();
        checks++;
        if (mem_req_valid !== 1'b0 || fill_busy !== 1'b1) begin
            failures++;
            $display("FAIL req_release valid=%b busy=%b want 0 1", mem_req_valid, fill_busy);
        end
        for (int i = 0; i < 16; i++) send_beat(32'h100 + 32'(i));
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (word_of(w) !== 32'h100 + 32'(w)) begin
                failures++;
                $display("FAIL req_order word%0d got=%h want=%h", w, word_of(w), 32'h100 + 32'(w));
            end
        end
        tick();
        $display("test_req_hold done");
    endtask

    // Offset 15: beat i lands in word (15+i)%16, so word w holds beat (w+1)%16.
    task automatic test_wrap_gaps();
        start_fill(32'h0000_303C);
        checks++;
        if (mem_req_addr !== 32'h0000_303C) begin
            failures++;
            $display("FAIL wrap_addr got=%h want=0000303c", mem_req_addr);
        end
        grant();
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h300 + 32'(i));
            if (i < 15) begin
                checks++;
                if (fill_done !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_early_done beat=%0d fill_done=%b want 0", i, fill_done);
                end
                tick();
            end
        end
        checks++;
        if (fill_done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done fill_done=%b want 1", fill_done);
        end
        checks++;
        if (word_of(15) !== 32'h300 || word_of(0) !== 32'h301 || word_of(14) !== 32'h30F) begin
            failures++;
            $display("FAIL wrap_words w15=%h w0=%h w14=%h want 300 301 30f",
                     word_of(15), word_of(0), word_of(14));
        end
        tick();
        $display("test_wrap_gaps done");
    endtask

    task automatic test_reset_mid();
        start_fill(32'h0000_4000);
        grant();
        for (int i = 0; i < 7; i++) send_beat(32'h400 + 32'(i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req_valid, fill_busy, crit_word_valid, fill_done} !== 4'b0 ||
            mem_req_addr !== 32'h0 || crit_word !== 32'h0 || block_out !== '0) begin
            failures++;
            $display("FAIL midrst_clear flags=%b addr=%h crit=%h block_nonzero=%b want all zero",
                     {mem_req_valid, fill_busy, crit_word_valid, fill_done},
                     mem_req_addr, crit_word, block_out != '0);
        end
        for (int i = 7; i < 16; i++) send_beat(32'h400 + 32'(i));
        checks++;
        if (block_out !== '0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ignore block_nonzero=%b busy=%b done=%b want 0 0 0",
                     block_out != '0, fill_busy, fill_done);
        end
        start_fill(32'h0000_5004);
        grant();
        for (int i = 0; i < 16; i++) send_beat(32'h500 + 32'(i));
        checks++;
        if (fill_done !== 1'b1 || word_of(1) !== 32'h500 || word_of(0) !== 32'h50F ||
            crit_word !== 32'h500) begin
            failures++;
            $display("FAIL midrst_refill done=%b w1=%h w0=%h crit=%h want 1 500 50f 500",
                     fill_done, word_of(1), word_of(0), crit_word);
        end
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_ignored_inputs();
        logic [511:0] saved;
        start_fill(32'h0000_6000);
        grant();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                fill_start = 1'b1;
                fill_addr  = 32'h0000_7024;
                tick();
                fill_start = 1'b0;
            end
            send_beat(32'h600 + 32'(i));
        end
        checks++;
        if (fill_done !== 1'b1 || mem_req_addr !== 32'h0000_6000 ||
            word_of(3) !== 32'h603 || word_of(15) !== 32'h60F) begin
            failures++;
            $display("FAIL ign_start done=%b addr=%h w3=%h w15=%h want 1 00006000 603 60f",
                     fill_done, mem_req_addr, word_of(3), word_of(15));
        end
        tick();
        saved = block_out;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) send_beat(32'hDEAD_0000 + 32'(k));
        mem_req_ready = 1'b0;
        checks++;
        if (block_out !== saved || fill_busy !== 1'b0 || mem_req_valid !== 1'b0 ||
            crit_word_valid !== 1'b0 || crit_word !== 32'h600) begin
            failures++;
            $display("FAIL ign_idle changed=%b busy=%b reqv=%b cv=%b crit=%h want 0 0 0 0 600",
                     block_out !== saved, fill_busy, mem_req_valid, crit_word_valid, crit_word);
        end
        $display("test_ignored_inputs done");
    endtask

    // Follows test_ignored_inputs: line 1 holds 0x600+w in word w.
    task automatic test_back_to_back();
        start_fill(32'h0000_8000);
        grant();
        tick();
        checks++;
        if (word_of(0) !== 32'h600 || word_of(9) !== 32'h609 || crit_word !== 32'h600) begin
            failures++;
            $display("FAIL b2b_hold w0=%h w9=%h crit=%h want 600 609 600",
                     word_of(0), word_of(9), crit_word);
        end
        send_beat(32'h800);
        checks++;
        if (crit_word !== 32'h800 || crit_word_valid !== 1'b1 ||
            word_of(0) !== 32'h800 || word_of(1) !== 32'h601) begin
            failures++;
            $display("FAIL b2b_first crit=%h cv=%b w0=%h w1=%h want 800 1 800 601",
                     crit_word, crit_word_valid, word_of(0), word_of(1));
        end
        for (int i = 1; i < 16; i++) send_beat(32'h800 + 32'(i));
        checks++;
        if (fill_done !== 1'b1 || word_of(15) !== 32'h80F || crit_word !== 32'h800) begin
            failures++;
            $display("FAIL b2b_done done=%b w15=%h crit=%h want 1 80f 800",
                     fill_done, word_of(15), crit_word);
        end
        tick();
        $display("test_back_to_back done");
    endtask

    initial begin
        tick();
        test_reset();
        test_crit_first();
        test_req_hold();
        test_wrap_gaps();
        test_reset_mid();
        test_ignored_inputs();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
